// File: rtl/ddr_traffic_gen_chk.sv
// ddr_traffic_gen_chk: writes an incrementing pattern into the ctrl write FIFO, reads it back and checks it.
module ddr_traffic_gen_chk #(
  parameter int DW         = 16,
  parameter int NUM_WORDS  = 4096,
  parameter int SEED       = 0,
  parameter int GAP_CYCLES = 64,
  parameter int TIMEOUT    = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          wr_en,
  output logic [DW-1:0] wr_data,
  output logic          rd_mem_enable,
  input  logic          rd_valid,
  output logic          rd_en,
  input  logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [15:0]   err_cnt,
  output logic [15:0]   first_err_idx
);
  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] wr_idx_q, wr_idx_d, rd_iss_q, rd_iss_d, chk_idx_q, chk_idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          cmp_q, pass_q, pass_d, timeout_q, timeout_d, mism;
  logic [15:0]   err_q, err_d, ferr_q, ferr_d;
  assign wr_en         = state_q == WRITE;
  assign wr_data       = DW'(SEED + 32'(wr_idx_q));
  assign rd_mem_enable = state_q == READ;
  assign rd_en         = state_q == READ && rd_valid && rd_iss_q < CW'(NUM_WORDS);
  assign busy          = state_q == WRITE || state_q == GAP || state_q == READ;
  assign done          = state_q == DONE;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign err_cnt       = err_q;
  assign first_err_idx = ferr_q;
  assign mism          = cmp_q && rd_data != DW'(SEED + 32'(chk_idx_q));
  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_iss_d  = rd_iss_q;
    gap_d     = gap_q;
    idle_d    = idle_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    chk_idx_d = cmp_q ? chk_idx_q + CW'(1) : chk_idx_q;
    err_d     = mism && !(&err_q) ? err_q + 16'd1 : err_q;
    ferr_d    = mism && ferr_q == 16'hFFFF ? 16'(chk_idx_q) : ferr_q;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      state_d   = WRITE;
      wr_idx_d  = '0;
      rd_iss_d  = '0;
      chk_idx_d = '0;
      gap_d     = '0;
      idle_d    = '0;
      pass_d    = 1'b0;
      timeout_d = 1'b0;
      err_d     = '0;
      ferr_d    = 16'hFFFF;
    end else if (state_q == WRITE) begin
      wr_idx_d = wr_idx_q + CW'(1);
      state_d  = wr_idx_q == CW'(NUM_WORDS - 1) ? GAP : WRITE;
    end else if (state_q == GAP) begin
      gap_d   = gap_q + GW'(1);
      state_d = gap_q == GW'(GAP_CYCLES - 1) ? READ : GAP;
    end else if (state_q == READ) begin
      rd_iss_d = rd_iss_q + CW'(rd_en);
      idle_d   = rd_en ? '0 : idle_q + TW'(1);
      // the final compare lands in this cycle, so pass must see its error update
      if (cmp_q && chk_idx_q == CW'(NUM_WORDS - 1)) begin
        state_d = DONE;
        pass_d  = err_d == 16'd0;
      end else if (idle_d == TW'(TIMEOUT)) begin
        state_d   = DONE;
        timeout_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_idx_q  <= '0;
      rd_iss_q  <= '0;
      chk_idx_q <= '0;
      gap_q     <= '0;
      idle_q    <= '0;
      cmp_q     <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
      ferr_q    <= 16'hFFFF;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_iss_q  <= rd_iss_d;
      chk_idx_q <= chk_idx_d;
      gap_q     <= gap_d;
      idle_q    <= idle_d;
      cmp_q     <= rd_en;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      ferr_q    <= ferr_d;
    end
  end
endmodule
